// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative cipher cores: inverse S-box,
// GF(2^8) helpers, the sequencing FSM encoding and key-size constants.
package aes_pkg;

  localparam int AES128_NK = 4;
  localparam int AES128_NR = 10;
  localparam int AES192_NK = 6;
  localparam int AES192_NR = 12;
  localparam int AES256_NK = 8;
  localparam int AES256_NR = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_fsm_e;

  // Entry for input byte b sits at bits [8*(255-b)+7 : 8*(255-b)].
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[8*(255 - int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES decryption round, purely combinational. The final round skips
// InvMixColumns; the key is added before mixing (standard inverse cipher order).
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] state_out
);

  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] keyed;
  logic [127:0] mixed;

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  // Byte 4*c+r is row r, column c; row r rotates right by r positions.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127-8*(4*c+r) -: 8] = state_in[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
  end

  always_comb begin
    subbed = '0;
    for (int i = 0; i < 16; i++) begin
      subbed[127-8*i -: 8] = inv_sbox(shifted[127-8*i -: 8]);
    end
  end

  assign keyed = subbed ^ round_key;

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = inv_mix_col(keyed[127-32*c -: 32]);
    end
  end

  assign state_out = final_round ? keyed : mixed;

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher, one round per clock, valid/ready on both sides.
// state | meaning
// IDLE  | waiting for a ciphertext block; in_ready high
// ROUND | applying inverse rounds, rnd counts Nr-1 down to 0
// DONE  | plaintext held on pt_out with out_valid until out_ready
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [128*(Nr+1)-1:0]  round_keys,
  input  logic [127:0]           ct_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [127:0]           pt_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  if (Nr != Nk + 6) begin : g_bad_cfg
    $error("aes_inv_cipher_iter: Nr must equal Nk+6");
  end

  aes_fsm_e     fsm;
  logic [3:0]   rnd;
  logic [127:0] blk;
  logic [127:0] rk_cur;
  logic [127:0] rk_first;
  logic [127:0] blk_nxt;

  // Key i lives at the slice starting 128*(Nr-i); rk[Nr] is the LSB slice.
  assign rk_cur   = round_keys[128*(Nr - int'(rnd)) +: 128];
  assign rk_first = round_keys[127:0];

  aes_inv_round u_round (
    .state_in    (blk),
    .round_key   (rk_cur),
    .final_round (rnd == 4'd0),
    .state_out   (blk_nxt)
  );

  assign in_ready = (fsm == IDLE) && !rst;
  assign busy     = (fsm != IDLE);
  assign pt_out   = blk;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      rnd       <= 4'd0;
      blk       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            blk <= ct_in ^ rk_first;
            rnd <= 4'(Nr - 1);
            fsm <= ROUND;
          end
        end
        ROUND: begin
          blk <= blk_nxt;
          if (rnd == 4'd0) begin
            fsm       <= DONE;
            out_valid <= 1'b1;
          end else begin
            rnd <= rnd - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter: FIPS-197 C.1/C.2/C.3 vectors,
// latency, backpressure, streaming, mid-block reset and busy-input masking.
module tb_aes_inv_cipher_iter;

  localparam int W128 = 128*11;
  localparam int W192 = 128*13;
  localparam int W256 = 128*15;

  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [W128-1:0] rk128;
  logic [127:0]    ct128, pt128;
  logic            iv128, ir128, ov128, or128, busy128;

  logic [W192-1:0] rk192;
  logic [127:0]    ct192, pt192;
  logic            iv192, ir192, ov192, or192, busy192;

  logic [W256-1:0] rk256;
  logic [127:0]    ct256, pt256;
  logic            iv256, ir256, ov256, or256, busy256;

  int n_checks = 0;
  int n_pass   = 0;

  aes_inv_cipher_iter #(.Nk(4), .Nr(10)) u128 (
    .clk(clk), .rst(rst), .round_keys(rk128), .ct_in(ct128), .in_valid(iv128),
    .in_ready(ir128), .pt_out(pt128), .out_valid(ov128), .out_ready(or128), .busy(busy128));

  aes_inv_cipher_iter #(.Nk(6), .Nr(12)) u192 (
    .clk(clk), .rst(rst), .round_keys(rk192), .ct_in(ct192), .in_valid(iv192),
    .in_ready(ir192), .pt_out(pt192), .out_valid(ov192), .out_ready(or192), .busy(busy192));

  aes_inv_cipher_iter #(.Nk(8), .Nr(14)) u256 (
    .clk(clk), .rst(rst), .round_keys(rk256), .ct_in(ct256), .in_valid(iv256),
    .in_ready(ir256), .pt_out(pt256), .out_valid(ov256), .out_ready(or256), .busy(busy256));

  // Forward S-box from first principles (field inverse + affine map) for key expansion.
  function automatic logic [7:0] tb_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = tb_xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] tb_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int i = 1; i < 256; i++) if (tb_mul(x, 8'(i)) == 8'h01) inv = 8'(i);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {tb_sbox(w[31:24]), tb_sbox(w[23:16]), tb_sbox(w[15:8]), tb_sbox(w[7:0])};
  endfunction

  // Key bytes are 00,01,02,...; words shift in so w[0] ends at the MSB.
  function automatic logic [1919:0] expand(input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] bus;
    int            nw;
    nw  = 4 * (nk + 7);
    rc  = 8'h01;
    bus = '0;
    for (int i = 0; i < nw; i++) begin
      if (i < nk) begin
        w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = tb_xtime(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
      end
      bus = {bus[1887:0], w[i]};
    end
    return bus;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    iv128 = 1'b1; ct128 = CT128; or128 = 1'b1;
    iv192 = 1'b1; ct192 = CT192; or192 = 1'b1;
    iv256 = 1'b1; ct256 = CT256; or256 = 1'b1;
    tick; tick; tick;
    n_checks++; if (ir128 !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", ir128); else n_pass++;
    n_checks++; if (ov128 !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", ov128); else n_pass++;
    n_checks++; if (pt128 !== 128'h0) $display("FAIL rst_pt_out: got %h want 0", pt128); else n_pass++;
    n_checks++; if (busy128 !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy128); else n_pass++;
    n_checks++; if ({ir192, ir256, busy192, busy256} !== 4'b0000)
      $display("FAIL rst_wide_cores: got %b want 0000", {ir192, ir256, busy192, busy256}); else n_pass++;
    iv128 = 1'b0; iv192 = 1'b0; iv256 = 1'b0;
    rst = 1'b0;
    tick;
    n_checks++; if (ir128 !== 1'b1) $display("FAIL post_rst_in_ready: got %b want 1", ir128); else n_pass++;
    n_checks++; if (busy128 !== 1'b0) $display("FAIL post_rst_not_accepted: busy %b want 0", busy128); else n_pass++;
  endtask

  task automatic test_aes128;
    int lat, ir_bad;
    ct128 = CT128; or128 = 1'b1;
    n_checks++; if (ir128 !== 1'b1) $display("FAIL a128_ready_before: got %b want 1", ir128); else n_pass++;
    iv128 = 1'b1;
    tick;
    iv128 = 1'b0;
    lat = 0; ir_bad = 0;
    while (ov128 !== 1'b1 && lat < 40) begin
      if (ir128 !== 1'b0) ir_bad++;
      tick; lat++;
    end
    if (ir128 !== 1'b0) ir_bad++;
    n_checks++; if (lat !== 10) $display("FAIL a128_latency: got %0d want 10", lat); else n_pass++;
    n_checks++; if (pt128 !== PT) $display("FAIL a128_pt: got %h want %h", pt128, PT); else n_pass++;
    n_checks++; if (ir_bad !== 0) $display("FAIL a128_in_ready_low: %0d high samples want 0", ir_bad); else n_pass++;
    tick;
    n_checks++; if ({ov128, ir128} !== 2'b01) $display("FAIL a128_handshake: ov,ir %b want 01", {ov128, ir128}); else n_pass++;
  endtask

  task automatic test_aes192;
    int lat;
    ct192 = CT192; or192 = 1'b1; iv192 = 1'b1;
    tick;
    iv192 = 1'b0;
    lat = 0;
    while (ov192 !== 1'b1 && lat < 40) begin tick; lat++; end
    n_checks++; if (lat !== 12) $display("FAIL a192_latency: got %0d want 12", lat); else n_pass++;
    n_checks++; if (pt192 !== PT) $display("FAIL a192_pt: got %h want %h", pt192, PT); else n_pass++;
    tick;
    n_checks++; if ({ov192, ir192} !== 2'b01) $display("FAIL a192_handshake: ov,ir %b want 01", {ov192, ir192}); else n_pass++;
  endtask

  task automatic test_aes256;
    int lat;
    ct256 = CT256; or256 = 1'b1; iv256 = 1'b1;
    tick;
    iv256 = 1'b0;
    lat = 0;
    while (ov256 !== 1'b1 && lat < 40) begin tick; lat++; end
    n_checks++; if (lat !== 14) $display("FAIL a256_latency: got %0d want 14", lat); else n_pass++;
    n_checks++; if (pt256 !== PT) $display("FAIL a256_pt: got %h want %h", pt256, PT); else n_pass++;
    tick;
    n_checks++; if ({ov256, ir256} !== 2'b01) $display("FAIL a256_handshake: ov,ir %b want 01", {ov256, ir256}); else n_pass++;
  endtask

  task automatic test_backpressure;
    int lat, ov_bad, pt_bad, ir_bad;
    or128 = 1'b0; ct128 = CT128; iv128 = 1'b1;
    tick;
    lat = 0;
    while (ov128 !== 1'b1 && lat < 40) begin tick; lat++; end
    n_checks++; if (lat !== 10) $display("FAIL bp_latency: got %0d want 10", lat); else n_pass++;
    ov_bad = 0; pt_bad = 0; ir_bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (ov128 !== 1'b1) ov_bad++;
      if (pt128 !== PT) pt_bad++;
      if (ir128 !== 1'b0) ir_bad++;
    end
    n_checks++; if (ov_bad !== 0) $display("FAIL bp_out_valid_held: %0d drops want 0", ov_bad); else n_pass++;
    n_checks++; if (pt_bad !== 0) $display("FAIL bp_pt_stable: %0d changes want 0", pt_bad); else n_pass++;
    n_checks++; if (ir_bad !== 0) $display("FAIL bp_in_ready_low: %0d high want 0", ir_bad); else n_pass++;
    or128 = 1'b1;
    tick;
    n_checks++; if ({ov128, busy128, ir128} !== 3'b001)
      $display("FAIL bp_no_accept_on_handshake: ov,busy,ir %b want 001", {ov128, busy128, ir128}); else n_pass++;
    tick;
    n_checks++; if ({busy128, ir128} !== 2'b10)
      $display("FAIL bp_second_accept: busy,ir %b want 10", {busy128, ir128}); else n_pass++;
    iv128 = 1'b0;
    lat = 0;
    while (ov128 !== 1'b1 && lat < 40) begin tick; lat++; end
    n_checks++; if (lat !== 10) $display("FAIL bp_second_latency: got %0d want 10", lat); else n_pass++;
    n_checks++; if (pt128 !== PT) $display("FAIL bp_second_pt: got %h want %h", pt128, PT); else n_pass++;
    tick;
  endtask

  task automatic test_back_to_back;
    int cyc, nout, pt_bad;
    int times [3];
    iv128 = 1'b1; or128 = 1'b1; ct128 = CT128;
    cyc = 0; nout = 0; pt_bad = 0;
    times = '{0, 0, 0};
    while (nout < 3 && cyc < 60) begin
      tick; cyc++;
      if (ov128 === 1'b1) begin
        if (pt128 !== PT) pt_bad++;
        times[nout] = cyc;
        nout++;
        if (nout == 3) iv128 = 1'b0;
      end
    end
    n_checks++; if (nout !== 3) $display("FAIL b2b_count: got %0d want 3", nout); else n_pass++;
    n_checks++; if (times[0] !== 11) $display("FAIL b2b_first: cycle %0d want 11", times[0]); else n_pass++;
    n_checks++; if (times[1] - times[0] !== 12) $display("FAIL b2b_gap1: got %0d want 12", times[1] - times[0]); else n_pass++;
    n_checks++; if (times[2] - times[1] !== 12) $display("FAIL b2b_gap2: got %0d want 12", times[2] - times[1]); else n_pass++;
    n_checks++; if (pt_bad !== 0) $display("FAIL b2b_pt: %0d wrong want 0", pt_bad); else n_pass++;
    tick;
    n_checks++; if ({ov128, busy128} !== 2'b00) $display("FAIL b2b_drain: ov,busy %b want 00", {ov128, busy128}); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int lat, ov_bad;
    or128 = 1'b1; ct128 = CT128; iv128 = 1'b1;
    tick;
    iv128 = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    n_checks++; if (busy128 !== 1'b1) $display("FAIL rm_busy_before: got %b want 1", busy128); else n_pass++;
    rst = 1'b1; iv128 = 1'b1;
    #1;
    n_checks++; if (ir128 !== 1'b0) $display("FAIL rm_in_ready_in_rst: got %b want 0", ir128); else n_pass++;
    tick; tick;
    n_checks++; if ({ov128, busy128} !== 2'b00) $display("FAIL rm_flushed: ov,busy %b want 00", {ov128, busy128}); else n_pass++;
    iv128 = 1'b0; rst = 1'b0;
    tick;
    n_checks++; if ({ir128, busy128} !== 2'b10) $display("FAIL rm_after_release: ir,busy %b want 10", {ir128, busy128}); else n_pass++;
    ov_bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick;
      if (ov128 !== 1'b0) ov_bad++;
    end
    n_checks++; if (ov_bad !== 0) $display("FAIL rm_no_out_valid: %0d pulses want 0", ov_bad); else n_pass++;
    iv128 = 1'b1;
    tick;
    iv128 = 1'b0;
    lat = 0;
    while (ov128 !== 1'b1 && lat < 40) begin tick; lat++; end
    n_checks++; if (lat !== 10) $display("FAIL rm_fresh_latency: got %0d want 10", lat); else n_pass++;
    n_checks++; if (pt128 !== PT) $display("FAIL rm_fresh_pt: got %h want %h", pt128, PT); else n_pass++;
    tick;
  endtask

  task automatic test_ignore_busy;
    int lat;
    or128 = 1'b1; ct128 = CT128; iv128 = 1'b1;
    tick;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      ct128 = {$urandom, $urandom, $urandom, $urandom};
      iv128 = i[0];
      tick; lat++;
    end
    iv128 = 1'b0;
    while (ov128 !== 1'b1 && lat < 40) begin tick; lat++; end
    n_checks++; if (lat !== 10) $display("FAIL ib_latency: got %0d want 10", lat); else n_pass++;
    n_checks++; if (pt128 !== PT) $display("FAIL ib_pt: got %h want %h", pt128, PT); else n_pass++;
    tick;
    n_checks++; if ({ov128, busy128} !== 2'b00) $display("FAIL ib_idle_after: ov,busy %b want 00", {ov128, busy128}); else n_pass++;
  endtask

  initial begin
    logic [1919:0] bus;
    rst = 1'b1;
    iv128 = 1'b0; iv192 = 1'b0; iv256 = 1'b0;
    or128 = 1'b0; or192 = 1'b0; or256 = 1'b0;
    ct128 = '0; ct192 = '0; ct256 = '0;
    bus = expand(4); rk128 = bus[W128-1:0];
    bus = expand(6); rk192 = bus[W192-1:0];
    bus = expand(8); rk256 = bus[W256-1:0];
    test_reset;
    test_aes128;
    test_aes192;
    test_aes256;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    test_ignore_busy;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
